vcxo_lock_monitor: RTL

//  Downstream of the VCXO discipline loop: consumes each signed freq_error measurement (x10 Hz units,
//  one per TCXO gate period) and qualifies loop lock with hysteresis. Drives a lock flag and a

---
 rtl/vcxo_lock_monitor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vcxo_lock_monitor.sv
// VCXO loop lock qualifier: ACQ/LOCKED/HOLD with good/bad hysteresis and sample timeout.
// Optional statistics (unlock_events, max_abs_err) are built when LOCK_STATS_EN is defined.
module vcxo_lock_monitor #(
  parameter int unsigned LOCK_WINDOW    = 2,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned UNLOCK_WINDOW  = 10,
  parameter int unsigned UNLOCK_COUNT   = 2,
  parameter int unsigned SAMPLE_TIMEOUT = 2457600
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        err_valid,
  input  logic [31:0] freq_error,
  input  logic        tx,
  output logic        locked,
  output logic        holdover,
  output logic [1:0]  lock_state,
  output logic        lock_lost,
  output logic [15:0] unlock_events,
  output logic [31:0] max_abs_err,
  input  logic        stats_clr
);

  localparam int TW = $clog2(SAMPLE_TIMEOUT) + 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [TW:0] TO_LAST = (TW + 1)'(SAMPLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_ACQ    = 2'd0,
    S_LOCKED = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_locked;
  logic          r_holdover;
  logic          r_lock_lost;
  logic [GW-1:0] r_good_cnt;
  logic [BW-1:0] r_bad_cnt;
  logic [TW-1:0] r_timeout;

  logic          w_accept;
  logic [31:0]   w_abs_err;
  logic          w_good;
  logic          w_bad;
  logic          w_good_hit;
  logic          w_bad_hit;
  logic [TW:0]   w_to_inc;
  logic          w_to_hit;
  logic          w_lose;

  assign w_accept = err_valid & ~tx;

  // Most-negative input has no positive twin in 32 bits, so it saturates.
  always_comb begin
    w_abs_err = freq_error;
    if (freq_error == 32'h8000_0000)
      w_abs_err = 32'h7FFF_FFFF;
    else if (freq_error[31])
      w_abs_err = ~freq_error + 32'd1;
  end

  assign w_good     = (w_abs_err <= 32'(LOCK_WINDOW));
  assign w_bad      = (w_abs_err >  32'(UNLOCK_WINDOW));
  assign w_good_hit = (r_good_cnt == GW'(LOCK_COUNT - 1));
  assign w_bad_hit  = (r_bad_cnt  == BW'(UNLOCK_COUNT - 1));
  assign w_to_inc   = {1'b0, r_timeout} + (TW + 1)'(1);
  assign w_to_hit   = (w_to_inc >= TO_LAST);

  // Every path back to ACQ from a qualified state raises lock_lost.
  assign w_lose = ((r_state == S_LOCKED) && w_accept && w_bad && w_bad_hit) ||
                  ((r_state == S_HOLD) && w_accept && w_bad) ||
                  ((r_state == S_HOLD) && !err_valid && !tx && w_to_hit);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= S_ACQ;
      r_locked    <= 1'b0;
      r_holdover  <= 1'b0;
      r_lock_lost <= 1'b0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_timeout   <= '0;
    end else begin
      r_lock_lost <= w_lose;
      if (w_lose) begin
        r_state    <= S_ACQ;
        r_locked   <= 1'b0;
        r_holdover <= 1'b0;
        r_good_cnt <= '0;
        r_bad_cnt  <= '0;
        r_timeout  <= '0;
      end else begin
        case (r_state)
          S_ACQ: begin
            if (w_accept) begin
              if (!w_good) begin
                r_good_cnt <= '0;
              end else if (w_good_hit) begin
                r_state    <= S_LOCKED;
                r_locked   <= 1'b1;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
                r_timeout  <= '0;
              end else begin
                r_good_cnt <= r_good_cnt + GW'(1);
              end
            end
          end
          S_LOCKED: begin
            if (w_accept) begin
              r_timeout <= '0;
              r_bad_cnt <= w_bad ? r_bad_cnt + BW'(1) : '0;
            end else if (tx || w_to_hit) begin
              r_state    <= S_HOLD;
              r_holdover <= 1'b1;
              r_timeout  <= '0;
            end else begin
              r_timeout <= w_to_inc[TW-1:0];
            end
          end
          S_HOLD: begin
            if (w_accept) begin
              r_state    <= S_LOCKED;
              r_holdover <= 1'b0;
              r_bad_cnt  <= '0;
              r_timeout  <= '0;
            end else if (!tx) begin
              r_timeout <= w_to_inc[TW-1:0];
            end
          end
          default: begin
            r_state    <= S_ACQ;
            r_locked   <= 1'b0;
            r_holdover <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = r_locked;
  assign holdover   = r_holdover;
  assign lock_state = r_state;
  assign lock_lost  = r_lock_lost;

`ifdef LOCK_STATS_EN
  logic [15:0] r_unlock_events;
  logic [31:0] r_max_abs_err;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_unlock_events <= '0;
      r_max_abs_err   <= '0;
    end else if (stats_clr) begin
      r_unlock_events <= '0;
      r_max_abs_err   <= '0;
    end else begin
      if (w_lose && (r_unlock_events != 16'hFFFF))
        r_unlock_events <= r_unlock_events + 16'd1;
      if ((r_state == S_LOCKED) && w_accept && (w_abs_err > r_max_abs_err))
        r_max_abs_err <= w_abs_err;
    end
  end

  assign unlock_events = r_unlock_events;
  assign max_abs_err   = r_max_abs_err;
`else
  logic w_unused_stats;
  assign w_unused_stats = stats_clr;
  assign unlock_events  = '0;
  assign max_abs_err    = '0;
`endif

endmodule
